// File: rtl/rrp_pkg.sv
// Shared definitions for the redundant signed-digit datapath: digit geometry,
// result width, the digit typedef, the illegal code and the converter states.
package rrp_pkg;

  function automatic int k_of(input int radix);
    return $clog2(radix);
  endfunction

  function automatic int d_of(input int radix);
    return $clog2(radix) + 1;
  endfunction

  function automatic int ow_of(input int radix, input int ndig);
    return $clog2(radix) * ndig + 1;
  endfunction

  localparam int RADIX_DEF = 4;
  localparam int K_DEF     = k_of(RADIX_DEF);
  localparam int D_DEF     = d_of(RADIX_DEF);

  typedef logic signed [D_DEF-1:0] digit_t;

  // -RADIX is representable in D bits but lies outside the legal digit set.
  localparam digit_t ILLEGAL_DIGIT = {1'b1, {K_DEF{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rrp_to_binary_if.sv
// Stream bus of the converter: redundant word in, two's-complement result out,
// each side with its own valid/ready pair.
interface rrp_to_binary_if
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int NDIG  = 9
);
  localparam int D  = d_of(RADIX);
  localparam int OW = ow_of(RADIX, NDIG);

  logic [D*NDIG-1:0] p_in;
  logic              in_valid;
  logic              in_ready;
  logic [OW-1:0]     res_out;
  logic              err_out;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output p_in, in_valid, out_ready,
    input  in_ready, res_out, err_out, out_valid
  );

  modport slave (
    input  p_in, in_valid, out_ready,
    output in_ready, res_out, err_out, out_valid
  );

endinterface

// File: rtl/rrp_otf_step.sv
// One on-the-fly conversion step: appends digit d to the Q/QM pair.
// Purely combinational; an illegal digit is flagged and treated as zero.
module rrp_otf_step
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int NDIG  = 9,
  localparam int K  = k_of(RADIX),
  localparam int D  = d_of(RADIX),
  localparam int OW = ow_of(RADIX, NDIG)
) (
  input  logic [OW-1:0] q,
  input  logic [OW-1:0] qm,
  input  logic [D-1:0]  d,
  output logic [OW-1:0] q_next,
  output logic [OW-1:0] qm_next,
  output logic          illegal
);

  localparam logic [D-1:0] ILLEGAL_CODE = {1'b1, {K{1'b0}}};

  logic [D-1:0]  d_eff;
  logic          d_neg;
  logic          d_pos;
  logic [K-1:0]  low;
  logic [K-1:0]  low_m1;
  logic [OW-1:0] q_shl;
  logic [OW-1:0] qm_shl;

  // NOTE: every variable gets a value at the top of the block, so no path
  // through it can leave one unassigned and infer a latch.
  always_comb begin
    illegal = (d == ILLEGAL_CODE);
    d_eff   = illegal ? '0 : d;
    d_neg   = d_eff[D-1];
    d_pos   = !d_neg && (d_eff != '0);
    // RADIX+d and RADIX-1+d reduce to the low K bits of d and d-1.
    low     = d_eff[K-1:0];
    low_m1  = low - K'(1);
    q_shl   = q << K;
    qm_shl  = qm << K;
    q_next  = (d_neg ? qm_shl : q_shl) | OW'(low);
    qm_next = (d_pos ? q_shl : qm_shl) | OW'(low_m1);
  end

endmodule

// File: rtl/rrp_to_binary.sv
// Sequential MSD-first converter from a redundant signed-digit word to a
// two's-complement integer, one digit per clock, with valid/ready on both sides.
module rrp_to_binary
  import rrp_pkg::*;
#(
  parameter int RADIX = 4,
  parameter int NDIG  = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  rrp_to_binary_if.slave   bus
);

  localparam int K  = k_of(RADIX);
  localparam int D  = d_of(RADIX);
  localparam int OW = ow_of(RADIX, NDIG);
  localparam int PW = D * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] shreg;
  logic [OW-1:0] q;
  logic [OW-1:0] qm;
  logic          err;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          load;
  logic          last_digit;
  logic [OW-1:0] q_step;
  logic [OW-1:0] qm_step;
  logic          illegal;

  rrp_otf_step #(
    .RADIX (RADIX),
    .NDIG  (NDIG)
  ) u_step (
    .q       (q),
    .qm      (qm),
    .d       (shreg[PW-1 -: D]),
    .q_next  (q_step),
    .qm_next (qm_step),
    .illegal (illegal)
  );

  assign load       = bus.in_valid && bus.in_ready;
  assign last_digit = (cnt == CW'(NDIG - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (load)          state_next = ST_CONV;
      ST_CONV: if (last_digit)    state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // armed keeps in_ready low for the whole reset and registered, so reset_n
  // never reaches an output combinationally.
  always_comb begin
    bus.in_ready  = (state == ST_IDLE) && armed;
    bus.out_valid = (state == ST_DONE);
  end

  assign bus.res_out = q;
  assign bus.err_out = err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      armed <= 1'b0;
      shreg <= '0;
      q     <= '0;
      qm    <= '1;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      armed <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            shreg <= bus.p_in;
            q     <= '0;
            qm    <= '1;
            err   <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_CONV: begin
          q     <= q_step;
          qm    <= qm_step;
          err   <= err | illegal;
          shreg <= shreg << D;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rrp_to_binary.sv
// Directed bench for rrp_to_binary (RADIX=4, NDIG=9): expected results are
// queued at load time and compared by a monitor on each output handshake.
module tb_rrp_to_binary;

  localparam int RADIX = 4;
  localparam int NDIG  = 9;
  localparam int OW    = 19;
  localparam int PW    = 27;

  typedef struct {
    logic [OW-1:0] res;
    logic          err;
  } exp_t;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_miss;
  exp_t sb[$];

  rrp_to_binary_if #(.RADIX(RADIX), .NDIG(NDIG)) bus ();

  rrp_to_binary #(.RADIX(RADIX), .NDIG(NDIG)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: the handshake completes on the following rising edge.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected output: res 0x%0h with empty scoreboard", bus.res_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_out", 32'(bus.res_out), 32'(e.res));
        check("err_out", 32'(bus.err_out), 32'(e.err));
      end
    end
  end

  task automatic load_word(input logic [PW-1:0] w, input logic [OW-1:0] r,
                           input logic e, input bit expect_out);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("in_ready before load", 32'(bus.in_ready), 32'd1);
    bus.p_in     = w;
    bus.in_valid = 1'b1;
    if (expect_out) sb.push_back('{res: r, err: e});
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.p_in     = PW'($urandom);
  endtask

  // Counts edges after the load edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic convert(input logic [PW-1:0] w, input logic [OW-1:0] r, input logic e);
    int n;
    load_word(w, r, e, 1'b1);
    wait_valid(n);
    check("latency", 32'(n), 32'(NDIG));
    @(posedge clock); #1;
  endtask

  initial begin
    int n;
    logic [OW-1:0] held;
    bit saw_valid;
    n_vec = 0;
    n_miss = 0;
    reset_n       = 1'b0;
    bus.p_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset res_out", 32'(bus.res_out), 32'd0);
    check("reset err_out", 32'(bus.err_out), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("in_ready after release", 32'(bus.in_ready), 32'd1);

    convert(27'd0, 19'h00000, 1'b0);
    convert({3'b001, 24'd0}, 19'h10000, 1'b0);
    convert({3'b001, 3'b111, 21'd0}, 19'h0C000, 1'b0);
    convert({9{3'b101}}, 19'h40001, 1'b0);
    convert({9{3'b011}}, 19'h3FFFF, 1'b0);
    convert({24'd0, 3'b111}, 19'h7FFFF, 1'b0);
    convert({24'd0, 3'b100}, 19'h00000, 1'b1);
    convert({3'b010, 3'b111, 3'b000, 3'b011, 3'b110, 3'b001, 3'b000, 3'b101, 3'b001},
            19'h1CA35, 1'b0);
    convert({3'b001, 3'b100, 21'd0}, 19'h10000, 1'b1);
    convert({9{3'b011}}, 19'h3FFFF, 1'b0);

    // Backpressure: hold the result for five cycles while in_valid pulses.
    bus.out_ready = 1'b0;
    load_word({3'b110, 21'd0, 3'b011}, 19'h60003, 1'b0, 1'b1);
    wait_valid(n);
    check("bp latency", 32'(n), 32'(NDIG));
    held = bus.res_out;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.p_in     = {9{3'b001}};
      @(posedge clock); #1;
      check("bp out_valid", 32'(bus.out_valid), 32'd1);
      check("bp res stable", 32'(bus.res_out), 32'(held));
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);

    // Reset during CONV, on the edge that would consume digit 4.
    load_word({9{3'b011}}, 19'h0, 1'b0, 1'b0);
    repeat (4) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("abort in_ready in reset", 32'(bus.in_ready), 32'd0);
    check("abort out_valid in reset", 32'(bus.out_valid), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("abort in_ready after release", 32'(bus.in_ready), 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("abort no out_valid", 32'(saw_valid), 32'd0);

    convert({21'd0, 3'b001, 3'b110}, 19'h00002, 1'b0);

    repeat (3) @(posedge clock);
    #1;
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
